// File: rtl/mips_pkg.sv
// Shared definitions for the 16-bit MIPS pipeline: widths, memory depth and
// the per-instruction control bundle carried between stages.
package mips_pkg;

  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 3;
  localparam int DMEM_DEPTH = 256;
  localparam int DMEM_AW    = $clog2(DMEM_DEPTH);

  typedef struct packed {
    logic RegWrite;
    logic MemtoReg;
    logic MemRead;
    logic MemWrite;
    logic Branch;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/memory_writeback_stage_data_memory.sv
// Single-port data memory: synchronous write, synchronous read.
// The array itself is never reset; only the read-word register clears so
// the MEM/WB read field starts at zero.
module data_memory
  import mips_pkg::*;
#(
  parameter int DW    = DATA_W,
  parameter int DEPTH = DMEM_DEPTH,
  parameter int AW    = DMEM_AW
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Store path: commit the write word on the edge after the store sits in EX/MEM.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Load path: a read in the same cycle as a write to that word returns the
  // old contents; with no read the last word is held.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/memory_writeback_stage.sv
// Back half of the pipeline: EX/MEM register, data memory, MEM/WB register
// and the write-back mux. Feeds branch redirect to fetch and the register
// file write port to decode.
module memory_writeback_stage
  import mips_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  ex_RegWrite,
  input  logic                  ex_MemtoReg,
  input  logic                  ex_MemRead,
  input  logic                  ex_MemWrite,
  input  logic                  ex_Branch,
  input  logic [DATA_W-1:0]     ex_alu_result,
  input  logic                  ex_zero,
  input  logic [DATA_W-1:0]     ex_store_data,
  input  logic [REG_ADDR_W-1:0] ex_write_register,
  input  logic [DATA_W-1:0]     ex_branch_target,
  output logic                  PC_Src,
  output logic [DATA_W-1:0]     branch_target,
  output logic                  RegWrite,
  output logic [REG_ADDR_W-1:0] write_register,
  output logic [DATA_W-1:0]     write_Data
);

  // EX/MEM fields
  ctrl_t                  exmem_ctrl_q, exmem_ctrl_d;
  logic [DATA_W-1:0]      exmem_alu_q;
  logic                   exmem_zero_q;
  logic [DATA_W-1:0]      exmem_store_q;
  logic [REG_ADDR_W-1:0]  exmem_wr_q;
  logic [DATA_W-1:0]      exmem_tgt_q;

  // MEM/WB fields (the read word lives in the memory's read register)
  logic                   memwb_regwrite_q;
  logic                   memwb_memtoreg_q;
  logic [REG_ADDR_W-1:0]  memwb_wr_q;
  logic [DATA_W-1:0]      memwb_alu_q;
  logic [DATA_W-1:0]      memwb_rdata;

  logic [DMEM_AW-1:0]     mem_index;

  // A flushed instruction keeps its data fields but loses every control bit,
  // so it can neither write memory, write a register nor redirect fetch.
  always_comb begin
    exmem_ctrl_d          = CTRL_NOP;
    exmem_ctrl_d.RegWrite = ex_RegWrite;
    exmem_ctrl_d.MemtoReg = ex_MemtoReg;
    exmem_ctrl_d.MemRead  = ex_MemRead;
    exmem_ctrl_d.MemWrite = ex_MemWrite;
    exmem_ctrl_d.Branch   = ex_Branch;
    if (flush) begin
      exmem_ctrl_d = CTRL_NOP;
    end
  end

  // EX/MEM register: captures the execute-stage results every edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exmem_ctrl_q  <= CTRL_NOP;
      exmem_alu_q   <= '0;
      exmem_zero_q  <= 1'b0;
      exmem_store_q <= '0;
      exmem_wr_q    <= '0;
      exmem_tgt_q   <= '0;
    end else begin
      exmem_ctrl_q  <= exmem_ctrl_d;
      exmem_alu_q   <= ex_alu_result;
      exmem_zero_q  <= ex_zero;
      exmem_store_q <= ex_store_data;
      exmem_wr_q    <= ex_write_register;
      exmem_tgt_q   <= ex_branch_target;
    end
  end

  // Byte address to word index: bit 0 dropped, bits above the array wrap.
  assign mem_index = exmem_alu_q[DMEM_AW:1];

  assign PC_Src        = exmem_ctrl_q.Branch & exmem_zero_q;
  assign branch_target = exmem_tgt_q;

  data_memory #(
    .DW    (DATA_W),
    .DEPTH (DMEM_DEPTH),
    .AW    (DMEM_AW)
  ) u_dmem (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .we_i    (exmem_ctrl_q.MemWrite),
    .re_i    (exmem_ctrl_q.MemRead),
    .addr_i  (mem_index),
    .wdata_i (exmem_store_q),
    .rdata_o (memwb_rdata)
  );

  // MEM/WB register: carries write-back control, destination and ALU result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memwb_regwrite_q <= 1'b0;
      memwb_memtoreg_q <= 1'b0;
      memwb_wr_q       <= '0;
      memwb_alu_q      <= '0;
    end else begin
      memwb_regwrite_q <= exmem_ctrl_q.RegWrite;
      memwb_memtoreg_q <= exmem_ctrl_q.MemtoReg;
      memwb_wr_q       <= exmem_wr_q;
      memwb_alu_q      <= exmem_alu_q;
    end
  end

  assign RegWrite       = memwb_regwrite_q;
  assign write_register = memwb_wr_q;
  assign write_Data     = memwb_memtoreg_q ? memwb_rdata : memwb_alu_q;

endmodule
